// File: rtl/flame_ctrl.sv
// Flame animation sequencer: turns a bomb cell into a sprite position and steps
// the sprite index 0..4..0 on frame boundaries.
module flame_ctrl #(
    parameter int          ORIGIN_X        = 64,
    parameter int          ORIGIN_Y        = 32,
    parameter int          GRID_W          = 15,
    parameter int          GRID_H          = 13,
    parameter int          FRAMES_PER_STEP = 4,
    parameter logic [9:0]  OFFSCREEN       = 10'h3FF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       explode,
    input  logic [3:0] bomb_cellX,
    input  logic [3:0] bomb_cellY,
    output logic [9:0] flame_centerX,
    output logic [9:0] flame_centerY,
    output logic [2:0] sprite_num,
    output logic       flame_active,
    output logic       flame_done
);

    localparam int          CW   = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAMES_PER_STEP - 1);

    typedef enum logic [1:0] {IDLE, ARMED, GROW, SHRINK} state_t;

    state_t        state_q, state_d;
    logic [9:0]    pos_x_q, pos_x_d;
    logic [9:0]    pos_y_q, pos_y_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    cx_q, cx_d;
    logic [9:0]    cy_q, cy_d;
    logic [2:0]    spr_q, spr_d;
    logic          act_q, act_d;
    logic          done_q, done_d;

    logic          cell_valid;
    logic          step_due;

    assign cell_valid = ({1'b0, bomb_cellX} < 5'(GRID_W)) &&
                        ({1'b0, bomb_cellY} < 5'(GRID_H));
    assign step_due   = frame_tick && (cnt_q == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pos_x_q <= '0;
            pos_y_q <= '0;
            cnt_q   <= '0;
            cx_q    <= OFFSCREEN;
            cy_q    <= OFFSCREEN;
            spr_q   <= '0;
            act_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            cnt_q   <= cnt_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            spr_q   <= spr_d;
            act_q   <= act_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        cnt_d   = cnt_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        spr_d   = spr_q;
        act_d   = act_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // A tick arriving with the request is deliberately not counted.
                if (explode && cell_valid) begin
                    state_d = ARMED;
                    pos_x_d = 10'(ORIGIN_X) + 10'({bomb_cellX, 5'b0});
                    pos_y_d = 10'(ORIGIN_Y) + 10'({bomb_cellY, 5'b0});
                end
            end
            ARMED: begin
                if (frame_tick) begin
                    state_d = GROW;
                    cx_d    = pos_x_q;
                    cy_d    = pos_y_q;
                    spr_d   = 3'd0;
                    act_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            GROW: begin
                if (step_due) begin
                    cnt_d = '0;
                    if (spr_q == 3'd4) begin
                        state_d = SHRINK;
                        spr_d   = 3'd3;
                    end else begin
                        spr_d = spr_q + 3'd1;
                    end
                end else if (frame_tick) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SHRINK: begin
                if (step_due) begin
                    cnt_d = '0;
                    if (spr_q == 3'd0) begin
                        state_d = IDLE;
                        cx_d    = OFFSCREEN;
                        cy_d    = OFFSCREEN;
                        act_d   = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        spr_d = spr_q - 3'd1;
                    end
                end else if (frame_tick) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign flame_centerX = cx_q;
    assign flame_centerY = cy_q;
    assign sprite_num    = spr_q;
    assign flame_active  = act_q;
    assign flame_done    = done_q;

endmodule

// File: tb/tb_flame_ctrl.sv
// Bench for flame_ctrl: one instance with 4 frames per step, one with 1.
module tb_flame_ctrl;

    localparam logic [9:0] OFF = 10'h3FF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       tick_a, ex_a, tick_b, ex_b;
    logic [3:0] cx_a, cy_a, cx_b, cy_b;
    logic [9:0] x_a, y_a, x_b, y_b;
    logic [2:0] spr_a, spr_b;
    logic       act_a, done_a, act_b, done_b;

    flame_ctrl #(.FRAMES_PER_STEP(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .frame_tick(tick_a), .explode(ex_a),
        .bomb_cellX(cx_a), .bomb_cellY(cy_a),
        .flame_centerX(x_a), .flame_centerY(y_a), .sprite_num(spr_a),
        .flame_active(act_a), .flame_done(done_a)
    );

    flame_ctrl #(.FRAMES_PER_STEP(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .frame_tick(tick_b), .explode(ex_b),
        .bomb_cellX(cx_b), .bomb_cellY(cy_b),
        .flame_centerX(x_b), .flame_centerY(y_b), .sprite_num(spr_b),
        .flame_active(act_b), .flame_done(done_b)
    );

    typedef struct {
        logic       ex;
        logic       tk;
        logic [3:0] cx;
        logic [3:0] cy;
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] spr;
        logic       act;
        logic       done;
    } vec_t;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] spr;
        logic       act;
        logic       done;
        int         id;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [2:0] seq [9];

    task automatic chk(input string name, input int id, input logic [9:0] got, input logic [9:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s txn %0d: got %0d, expected %0d", name, id, got, want);
        end
    endtask

    task automatic apply(input bit sel, input logic ex, input logic tk,
                         input logic [3:0] cx, input logic [3:0] cy,
                         input logic [9:0] x, input logic [9:0] y, input logic [2:0] spr,
                         input logic act, input logic done, input int id);
        exp_t e;
        @(negedge clk);
        if (!sel) begin ex_a = ex; tick_a = tk; cx_a = cx; cy_a = cy; end
        else      begin ex_b = ex; tick_b = tk; cx_b = cx; cy_b = cy; end
        e.x = x; e.y = y; e.spr = spr; e.act = act; e.done = done; e.id = id;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (!sel) begin
            chk("centerX_a", e.id, x_a, e.x);
            chk("centerY_a", e.id, y_a, e.y);
            chk("sprite_a",  e.id, 10'(spr_a), 10'(e.spr));
            chk("active_a",  e.id, 10'(act_a), 10'(e.act));
            chk("done_a",    e.id, 10'(done_a), 10'(e.done));
            $display("txn %0d dut_a ex=%0b tk=%0b cell=(%0d,%0d) -> x=%0d y=%0d spr=%0d act=%0b done=%0b",
                     e.id, ex, tk, cx, cy, x_a, y_a, spr_a, act_a, done_a);
        end else begin
            chk("centerX_b", e.id, x_b, e.x);
            chk("centerY_b", e.id, y_b, e.y);
            chk("sprite_b",  e.id, 10'(spr_b), 10'(e.spr));
            chk("active_b",  e.id, 10'(act_b), 10'(e.act));
            chk("done_b",    e.id, 10'(done_b), 10'(e.done));
            $display("txn %0d dut_b ex=%0b tk=%0b cell=(%0d,%0d) -> x=%0d y=%0d spr=%0d act=%0b done=%0b",
                     e.id, ex, tk, cx, cy, x_b, y_b, spr_b, act_b, done_b);
        end
        ex_a = 0; tick_a = 0; ex_b = 0; tick_b = 0;
    endtask

    // Expected outputs of the FPS=4 instance after its k-th tick following activation.
    task automatic exp_after(input int k, output logic [9:0] x, output logic [9:0] y,
                             output logic [2:0] spr, output logic act, output logic done);
        if (k < 36) begin
            x = 10'd160; y = 10'd96; spr = seq[k / 4]; act = 1'b1; done = 1'b0;
        end else begin
            x = OFF; y = OFF; spr = 3'd0; act = 1'b0; done = 1'b1;
        end
    endtask

    initial begin
        vec_t       tbl [8];
        logic [9:0] ex_x, ex_y;
        logic [2:0] ex_s;
        logic       ex_act, ex_done;
        int         id = 0;

        seq[0] = 3'd0; seq[1] = 3'd1; seq[2] = 3'd2; seq[3] = 3'd3; seq[4] = 3'd4;
        seq[5] = 3'd3; seq[6] = 3'd2; seq[7] = 3'd1; seq[8] = 3'd0;

        // {ex, tk, cx, cy, x, y, spr, act, done}
        tbl[0] = '{1'b0, 1'b1, 4'd0,  4'd0,  OFF,     OFF,    3'd0, 1'b0, 1'b0}; // idle tick
        tbl[1] = '{1'b1, 1'b0, 4'd15, 4'd0,  OFF,     OFF,    3'd0, 1'b0, 1'b0}; // X out of grid
        tbl[2] = '{1'b0, 1'b1, 4'd0,  4'd0,  OFF,     OFF,    3'd0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 4'd0,  4'd13, OFF,     OFF,    3'd0, 1'b0, 1'b0}; // Y out of grid
        tbl[4] = '{1'b0, 1'b1, 4'd0,  4'd0,  OFF,     OFF,    3'd0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 4'd3,  4'd2,  OFF,     OFF,    3'd0, 1'b0, 1'b0}; // tick with explode
        tbl[6] = '{1'b0, 1'b0, 4'd0,  4'd0,  OFF,     OFF,    3'd0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 4'd0,  4'd0,  10'd160, 10'd96, 3'd0, 1'b1, 1'b0}; // activation

        reset_n = 1'b0;
        tick_a = 0; ex_a = 0; cx_a = 0; cy_a = 0;
        tick_b = 0; ex_b = 0; cx_b = 0; cy_b = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_centerX", 0, x_a, OFF);
        chk("rst_centerY", 0, y_a, OFF);
        chk("rst_sprite",  0, 10'(spr_a), 10'd0);
        chk("rst_active",  0, 10'(act_a), 10'd0);
        chk("rst_done",    0, 10'(done_b), 10'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            apply(0, tbl[i].ex, tbl[i].tk, tbl[i].cx, tbl[i].cy,
                  tbl[i].x, tbl[i].y, tbl[i].spr, tbl[i].act, tbl[i].done, id++);
        end

        // Full animation: a quiet cycle between ticks checks that outputs hold.
        for (int n = 1; n <= 36; n++) begin
            exp_after(n - 1, ex_x, ex_y, ex_s, ex_act, ex_done);
            apply(0, n == 10, 1'b0, 4'd5, 4'd5, ex_x, ex_y, ex_s, ex_act, ex_done, id++);
            exp_after(n, ex_x, ex_y, ex_s, ex_act, ex_done);
            apply(0, n == 36, 1'b1, 4'd5, 4'd5, ex_x, ex_y, ex_s, ex_act, ex_done, id++);
        end
        apply(0, 1'b0, 1'b0, 4'd0, 4'd0, OFF, OFF, 3'd0, 1'b0, 1'b0, id++);
        repeat (2) apply(0, 1'b0, 1'b1, 4'd0, 4'd0, OFF, OFF, 3'd0, 1'b0, 1'b0, id++);

        // Reset while growing at sprite 2.
        apply(0, 1'b1, 1'b0, 4'd3, 4'd2, OFF, OFF, 3'd0, 1'b0, 1'b0, id++);
        apply(0, 1'b0, 1'b1, 4'd0, 4'd0, 10'd160, 10'd96, 3'd0, 1'b1, 1'b0, id++);
        for (int n = 1; n <= 8; n++) begin
            exp_after(n, ex_x, ex_y, ex_s, ex_act, ex_done);
            apply(0, 1'b0, 1'b1, 4'd0, 4'd0, ex_x, ex_y, ex_s, ex_act, ex_done, id++);
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_centerX", id, x_a, OFF);
        chk("midrst_centerY", id, y_a, OFF);
        chk("midrst_sprite",  id, 10'(spr_a), 10'd0);
        chk("midrst_active",  id, 10'(act_a), 10'd0);
        chk("midrst_done",    id, 10'(done_a), 10'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int n = 0; n < 40; n++) begin
            apply(0, 1'b0, n[0], 4'd0, 4'd0, OFF, OFF, 3'd0, 1'b0, 1'b0, id++);
        end

        // One frame per step, at the far corner cell of the board.
        apply(1, 1'b1, 1'b0, 4'd14, 4'd12, OFF, OFF, 3'd0, 1'b0, 1'b0, id++);
        apply(1, 1'b0, 1'b1, 4'd0, 4'd0, 10'd512, 10'd416, 3'd0, 1'b1, 1'b0, id++);
        for (int n = 1; n <= 9; n++) begin
            if (n < 9)
                apply(1, 1'b0, 1'b1, 4'd0, 4'd0, 10'd512, 10'd416, seq[n], 1'b1, 1'b0, id++);
            else
                apply(1, 1'b0, 1'b1, 4'd0, 4'd0, OFF, OFF, 3'd0, 1'b0, 1'b1, id++);
        end
        apply(1, 1'b0, 1'b0, 4'd0, 4'd0, OFF, OFF, 3'd0, 1'b0, 1'b0, id++);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
